// File: rtl/fsm_link_driver_if.sv
// Handshake and link bundle for fsm_link_driver: request framing, payload
// stream, peer-state feedback and the byte/enable link toward the peer FSM.
interface fsm_link_driver_if;
   // Command source side
   logic       req_valid;
   logic [4:0] req_len;
   logic       req_ready;
   logic       pl_valid;
   logic [7:0] pl_data;
   logic       pl_ready;
   // Peer link side
   logic [2:0] peer_state;
   logic [7:0] data;
   logic       en;
   // Status
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   // Driver view
   modport master (
      input  req_valid, req_len, pl_valid, pl_data, peer_state,
      output req_ready, pl_ready, data, en, busy, done, err, err_code
   );

   // Command source / peer / monitor view
   modport slave (
      output req_valid, req_len, pl_valid, pl_data, peer_state,
      input  req_ready, pl_ready, data, en, busy, done, err, err_code
   );
endinterface

// File: rtl/fsm_link_driver.sv
// Transmit-side driver for the IDLE/ON/OFF/WAIT byte/enable link. Opens the
// peer with START_BYTE, streams the framed payload, closes with STOP_BYTE plus
// an enable pulse, and follows the peer back to IDLE. Every output is a
// register loaded from the next-state logic.
module fsm_link_driver #(
   parameter logic [7:0]  START_BYTE = 8'hA5,
   parameter logic [7:0]  STOP_BYTE  = 8'hF0,
   parameter logic [7:0]  SAFE_BYTE  = 8'h0F,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   fsm_link_driver_if.master lnk
);

   localparam logic [2:0] PEER_IDLE = 3'b000;
   localparam logic [2:0] PEER_ON   = 3'b001;
   localparam logic [2:0] PEER_OFF  = 3'b010;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_STOP     = 2'b10;
   localparam logic [1:0] ERR_ZERO_LEN = 2'b11;

   // The counter holds cycles already spent in the wait state; the wait times
   // out on the edge that would make it reach TIMEOUT.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      D_IDLE,
      D_OPEN,
      D_WAIT_ON,
      D_PAYLOAD,
      D_STOP,
      D_WAIT_OFF,
      D_CLOSE,
      D_WAIT_IDLE
   } state_t;

   state_t     r_state,     w_state_nxt;
   logic [4:0] r_remaining, w_remaining_nxt;
   logic [7:0] r_cnt,       w_cnt_nxt;
   logic [7:0] r_data,      w_data_nxt;
   logic       r_en,        w_en_nxt;
   logic       r_req_ready, w_req_ready_nxt;
   logic       r_pl_ready,  w_pl_ready_nxt;
   logic       r_busy,      w_busy_nxt;
   logic       r_done,      w_done_nxt;
   logic       r_err,       w_err_nxt;
   logic [1:0] r_err_code,  w_err_code_nxt;

   logic w_accept;
   logic w_xfer;
   logic w_wait_state;
   logic w_timeout;

   assign w_accept     = lnk.req_valid && r_req_ready;
   assign w_xfer       = lnk.pl_valid && r_pl_ready;
   assign w_wait_state = (r_state == D_WAIT_ON) || (r_state == D_WAIT_OFF) ||
                         (r_state == D_WAIT_IDLE);
   assign w_timeout    = w_wait_state && (r_cnt == CNT_LAST);

   // Next state, counters and the next value of every registered output
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_data_nxt      = SAFE_BYTE;
      w_en_nxt        = 1'b0;
      w_done_nxt      = 1'b0;
      w_err_nxt       = 1'b0;
      w_err_code_nxt  = r_err_code;

      unique case (r_state)
         D_IDLE: begin
            if (w_accept) begin
               w_remaining_nxt = lnk.req_len;
               if (lnk.req_len == 5'd0) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_ZERO_LEN;
               end else begin
                  w_err_code_nxt = ERR_NONE;
                  w_state_nxt    = D_OPEN;
                  w_data_nxt     = START_BYTE;
                  w_en_nxt       = 1'b1;
               end
            end
         end

         D_OPEN: begin
            w_state_nxt = D_WAIT_ON;
         end

         D_WAIT_ON: begin
            if (lnk.peer_state == PEER_ON) begin
               w_state_nxt = D_PAYLOAD;
            end else if (w_timeout) begin
               w_state_nxt    = D_IDLE;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_TIMEOUT;
            end
         end

         D_PAYLOAD: begin
            if (w_xfer) begin
               if (lnk.pl_data == STOP_BYTE) begin
                  // Never forward a close byte as data; close the peer instead.
                  w_remaining_nxt = 5'd0;
                  w_err_code_nxt  = ERR_STOP;
                  w_state_nxt     = D_STOP;
                  w_data_nxt      = STOP_BYTE;
               end else begin
                  w_remaining_nxt = r_remaining - 5'd1;
                  w_data_nxt      = lnk.pl_data;
               end
            end else if (r_remaining == 5'd0) begin
               w_state_nxt = D_STOP;
               w_data_nxt  = STOP_BYTE;
            end
         end

         D_STOP: begin
            w_state_nxt = D_WAIT_OFF;
         end

         D_WAIT_OFF: begin
            if (lnk.peer_state == PEER_OFF) begin
               w_state_nxt = D_CLOSE;
               w_en_nxt    = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt    = D_IDLE;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_TIMEOUT;
            end
         end

         D_CLOSE: begin
            w_state_nxt = D_WAIT_IDLE;
         end

         D_WAIT_IDLE: begin
            if (lnk.peer_state == PEER_IDLE) begin
               w_state_nxt = D_IDLE;
               if (r_err_code == ERR_STOP) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_nxt    = D_IDLE;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_TIMEOUT;
            end
         end

         default: begin
            w_state_nxt = D_IDLE;
         end
      endcase

      // Restart the wait counter whenever a wait state is (re)entered.
      w_cnt_nxt = (w_wait_state && (w_state_nxt == r_state)) ? r_cnt + 8'd1 : 8'd0;

      w_req_ready_nxt = (w_state_nxt == D_IDLE);
      w_busy_nxt      = (w_state_nxt != D_IDLE);
      w_pl_ready_nxt  = (w_state_nxt == D_PAYLOAD) && (w_remaining_nxt != 5'd0);
   end

   // State and output registers, asynchronously reset to the safe idle link
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= D_IDLE;
         r_remaining <= 5'd0;
         r_cnt       <= 8'd0;
         r_data      <= SAFE_BYTE;
         r_en        <= 1'b0;
         r_req_ready <= 1'b1;
         r_pl_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_cnt       <= w_cnt_nxt;
         r_data      <= w_data_nxt;
         r_en        <= w_en_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_pl_ready  <= w_pl_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         r_err_code  <= w_err_code_nxt;
      end
   end

   assign lnk.data      = r_data;
   assign lnk.en        = r_en;
   assign lnk.req_ready = r_req_ready;
   assign lnk.pl_ready  = r_pl_ready;
   assign lnk.busy      = r_busy;
   assign lnk.done      = r_done;
   assign lnk.err       = r_err;
   assign lnk.err_code  = r_err_code;

endmodule

// File: tb/tb_fsm_link_driver.sv
// Bench for fsm_link_driver: a behavioural peer link FSM, a payload source
// queue, and per-scenario tasks that compare the observed link traffic and
// status against expectations derived from the transfer description.
`timescale 1ns/1ps
module tb_fsm_link_driver;

   localparam logic [7:0] START = 8'hA5;
   localparam logic [7:0] STOP  = 8'hF0;
   localparam logic [7:0] SAFE  = 8'h0F;
   localparam int         TO    = 255;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fsm_link_driver_if lnk();

   fsm_link_driver #(
      .START_BYTE (START),
      .STOP_BYTE  (STOP),
      .SAFE_BYTE  (SAFE),
      .TIMEOUT    (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .lnk (lnk)
   );

   // Ideal peer: reacts on the edge after it sees the driver's output.
   logic [2:0] peer_q;
   bit         peer_stuck = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) peer_q <= 3'b000;
      else if (!peer_stuck) begin
         case (peer_q)
            3'b000:  if (lnk.en && lnk.data == START) peer_q <= 3'b001;
            3'b001:  if (lnk.data == STOP) peer_q <= 3'b010;
            3'b010:  peer_q <= 3'b100;
            3'b100:  if (lnk.en) peer_q <= 3'b000;
            default: peer_q <= 3'b000;
         endcase
      end
   end
   assign lnk.peer_state = peer_q;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] src_q[$];
   logic [7:0] fil_q[$];
   logic [7:0] en1_q[$];
   logic [7:0] exp_q[$];
   int         res_done_k, res_err_k, res_ndone, res_nerr, res_consumed, res_late, res_k;
   bit         res_both;
   logic [1:0] res_code;
   logic [2:0] res_peer;
   logic [7:0] tr_data[32];
   logic       tr_en[32];

   // Issue one request and run until done/err or the cycle budget runs out.
   // Sample k is taken at the falling edge after the k-th rising edge past accept.
   task automatic run_xfer(input int len, input int vmode, input bit hold_req,
                           input int budget);
      bit fin;
      bit want;
      fin = 1'b0;
      fil_q.delete();
      en1_q.delete();
      res_done_k = -1; res_err_k = -1; res_ndone = 0; res_nerr = 0;
      res_consumed = 0; res_late = 0; res_both = 1'b0; res_code = 2'b00;
      res_peer = 3'b111;
      @(negedge clk);
      lnk.req_len   = 5'(len);
      lnk.req_valid = 1'b1;
      lnk.pl_valid  = 1'b0;
      res_k = 0;
      while (!fin && res_k < budget) begin
         @(negedge clk);
         if (hold_req) lnk.req_len = 5'($urandom_range(31, 0));
         else lnk.req_valid = 1'b0;
         if (res_k < 32) begin
            tr_data[res_k] = lnk.data;
            tr_en[res_k]   = lnk.en;
         end
         if (lnk.en) en1_q.push_back(lnk.data);
         else if (lnk.data != SAFE) fil_q.push_back(lnk.data);
         if (lnk.done && lnk.err) res_both = 1'b1;
         if (lnk.pl_ready && res_consumed >= len) res_late++;
         if (lnk.done) begin
            res_ndone++;
            if (res_done_k < 0) res_done_k = res_k;
         end
         if (lnk.err) begin
            res_nerr++;
            if (res_err_k < 0) res_err_k = res_k;
         end
         if (lnk.done || lnk.err) begin
            fin      = 1'b1;
            res_code = lnk.err_code;
            res_peer = lnk.peer_state;
         end
         case (vmode)
            0:       want = 1'b1;
            1:       want = res_k[0];
            default: want = ($urandom_range(99, 0) < 60);
         endcase
         if (fin) begin
            want          = 1'b0;
            lnk.req_valid = 1'b0;
         end
         lnk.pl_valid = want && (src_q.size() > 0);
         lnk.pl_data  = lnk.pl_valid ? src_q[0] : 8'($urandom);
         if (lnk.pl_valid && lnk.pl_ready) begin
            void'(src_q.pop_front());
            res_consumed++;
         end
         res_k++;
      end
      lnk.req_valid = 1'b0;
      lnk.pl_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      lnk.req_valid = 1'b0; lnk.req_len = 5'd0; lnk.pl_valid = 1'b0; lnk.pl_data = 8'h00;
      repeat (3) @(negedge clk);
      n_tests++; if (lnk.data !== SAFE) begin n_fail++; $display("FAIL reset_data: got %h want %h", lnk.data, SAFE); end
      n_tests++; if (lnk.en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", lnk.en); end
      n_tests++; if (lnk.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", lnk.req_ready); end
      n_tests++; if (lnk.pl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pl_ready: got %b want 0", lnk.pl_ready); end
      n_tests++; if (lnk.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", lnk.busy); end
      n_tests++; if ({lnk.done, lnk.err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {lnk.done, lnk.err}); end
      n_tests++; if (lnk.err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b want 00", lnk.err_code); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if ({lnk.req_ready, lnk.busy, lnk.en} !== 3'b100) begin n_fail++; $display("FAIL post_reset_idle: got %b want 100", {lnk.req_ready, lnk.busy, lnk.en}); end
   endtask

   task automatic test_ideal_len3();
      logic [7:0] ed[11];
      logic       ee[11];
      bit         ok;
      ed = '{START, SAFE, SAFE, 8'h11, 8'h22, 8'h33, STOP, SAFE, SAFE, SAFE, SAFE};
      ee = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      src_q = '{8'h11, 8'h22, 8'h33};
      run_xfer(3, 0, 1'b0, 40);
      ok = (res_k >= 11);
      if (ok) for (int i = 0; i < 11; i++) if (tr_data[i] !== ed[i] || tr_en[i] !== ee[i]) ok = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ideal3_link_trace: observed sequence differs from A5/1,0F,0F,11,22,33,F0,0F,0F/1,0F,0F"); end
      n_tests++; if (res_done_k !== 10) begin n_fail++; $display("FAIL ideal3_latency: done at %0d want 10", res_done_k); end
      n_tests++; if (res_nerr !== 0) begin n_fail++; $display("FAIL ideal3_err: got %0d err pulses want 0", res_nerr); end
      n_tests++; if (res_code !== 2'b00) begin n_fail++; $display("FAIL ideal3_code: got %b want 00", res_code); end
   endtask

   task automatic test_stall_len4();
      logic [7:0] ew[7];
      bit         ok;
      ew = '{8'h01, SAFE, SAFE, SAFE, 8'h7E, SAFE, 8'hC3};
      src_q = '{8'h01, 8'h0F, 8'h7E, 8'hC3};
      run_xfer(4, 1, 1'b0, 80);
      ok = (res_k >= 11);
      if (ok) for (int i = 0; i < 7; i++) if (tr_data[4 + i] !== ew[i]) ok = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_fill: payload window with 0F fill differs from expectation"); end
      n_tests++; if (res_consumed !== 4) begin n_fail++; $display("FAIL stall_consumed: got %0d want 4", res_consumed); end
      n_tests++; if (res_late !== 0) begin n_fail++; $display("FAIL stall_pl_ready_after_last: high %0d cycles want 0", res_late); end
      n_tests++; if (res_done_k !== 15 || res_nerr !== 0) begin n_fail++; $display("FAIL stall_done: done at %0d err %0d want 15 and 0", res_done_k, res_nerr); end
      n_tests++; if (en1_q.size() !== 2) begin n_fail++; $display("FAIL stall_en_pulses: got %0d want 2", en1_q.size()); end
   endtask

   task automatic test_stop_in_payload();
      bit ok;
      src_q = '{8'h12, STOP, 8'h34, 8'h56};
      exp_q = '{8'h12, STOP};
      run_xfer(4, 0, 1'b0, 80);
      ok = (fil_q.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (fil_q[i] !== exp_q[i]) ok = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_wire: %0d non-safe bytes, want 12 then a single F0", fil_q.size()); end
      n_tests++; if (res_consumed !== 2) begin n_fail++; $display("FAIL stop_consumed: got %0d want 2", res_consumed); end
      n_tests++; if (res_nerr !== 1 || res_ndone !== 0) begin n_fail++; $display("FAIL stop_outcome: err %0d done %0d want 1 and 0", res_nerr, res_ndone); end
      n_tests++; if (res_code !== 2'b10) begin n_fail++; $display("FAIL stop_code: got %b want 10", res_code); end
      n_tests++; if (res_peer !== 3'b000) begin n_fail++; $display("FAIL stop_peer_closed: peer %b at err want 000", res_peer); end
   endtask

   task automatic test_timeout();
      bit ok;
      peer_stuck = 1'b1;
      src_q = '{8'h55};
      run_xfer(1, 0, 1'b0, 400);
      n_tests++; if (res_err_k !== TO + 1) begin n_fail++; $display("FAIL timeout_cycle: err at %0d want %0d", res_err_k, TO + 1); end
      n_tests++; if (res_code !== 2'b01 || res_ndone !== 0) begin n_fail++; $display("FAIL timeout_code: code %b done %0d want 01 and 0", res_code, res_ndone); end
      @(negedge clk);
      n_tests++; if ({lnk.req_ready, lnk.busy, lnk.en, lnk.data} !== {3'b100, SAFE}) begin n_fail++; $display("FAIL timeout_idle: got %b/%h want 100/0f", {lnk.req_ready, lnk.busy, lnk.en}, lnk.data); end
      peer_stuck = 1'b0;
      src_q = '{8'h9A, 8'hBC};
      exp_q = '{8'h9A, 8'hBC, STOP};
      run_xfer(2, 0, 1'b0, 60);
      ok = (fil_q.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (fil_q[i] !== exp_q[i]) ok = 1'b0;
      n_tests++; if (!ok || res_done_k !== 9) begin n_fail++; $display("FAIL timeout_recover: done at %0d (want 9), wire ok=%0d", res_done_k, ok); end
   endtask

   task automatic test_zero_len_and_ignore();
      bit ok;
      bit stray;
      src_q.delete();
      run_xfer(0, 0, 1'b0, 10);
      n_tests++; if (res_err_k !== 0 || res_code !== 2'b11) begin n_fail++; $display("FAIL zero_len: err at %0d code %b want 0 and 11", res_err_k, res_code); end
      n_tests++; if (en1_q.size() !== 0 || fil_q.size() !== 0) begin n_fail++; $display("FAIL zero_len_link: en %0d bytes %0d want 0 and 0", en1_q.size(), fil_q.size()); end
      @(negedge clk);
      n_tests++; if ({lnk.err, lnk.req_ready, lnk.err_code} !== 4'b0111) begin n_fail++; $display("FAIL zero_len_single: got %b want 0111", {lnk.err, lnk.req_ready, lnk.err_code}); end
      src_q = '{8'h21, 8'h43};
      exp_q = '{8'h21, 8'h43, STOP};
      run_xfer(2, 0, 1'b1, 60);
      ok = (fil_q.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (fil_q[i] !== exp_q[i]) ok = 1'b0;
      n_tests++; if (!ok || res_consumed !== 2 || res_ndone !== 1) begin n_fail++; $display("FAIL busy_req_ignored: consumed %0d done %0d wire ok=%0d want 2,1,1", res_consumed, res_ndone, ok); end
      stray = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (lnk.en || lnk.busy || lnk.done || lnk.err) stray = 1'b1;
      end
      n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL busy_req_second_xfer: activity seen %b want 0", stray); end
   endtask

   task automatic test_async_reset();
      bit stray;
      @(negedge clk);
      lnk.req_len = 5'd8; lnk.req_valid = 1'b1; lnk.pl_valid = 1'b1; lnk.pl_data = 8'h33;
      @(negedge clk);
      lnk.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if ({lnk.busy, lnk.data} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL areset_setup: got %b/%h want 1/33", lnk.busy, lnk.data); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if ({lnk.data, lnk.en} !== {SAFE, 1'b0}) begin n_fail++; $display("FAIL areset_link: got %h/%b want 0f/0", lnk.data, lnk.en); end
      n_tests++; if ({lnk.busy, lnk.req_ready, lnk.pl_ready} !== 3'b010) begin n_fail++; $display("FAIL areset_status: got %b want 010", {lnk.busy, lnk.req_ready, lnk.pl_ready}); end
      lnk.pl_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      stray = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (lnk.done || lnk.err || lnk.busy || lnk.en) stray = 1'b1;
      end
      n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL areset_quiet: activity %b want 0", stray); end
   endtask

   task automatic test_random();
      logic [7:0] pl[$];
      logic [7:0] b;
      int         len, vmode, stop_idx, exp_cons;
      bit         hold, ok, exp_stop;
      for (int t = 0; t < 40; t++) begin
         len   = $urandom_range(16, 1);
         vmode = $urandom_range(2, 0);
         hold  = ($urandom_range(3, 0) == 0);
         pl.delete();
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if ($urandom_range(99, 0) < 4) b = STOP;
            else if ($urandom_range(99, 0) < 12) b = SAFE;
            pl.push_back(b);
         end
         // Expected: bytes up to the first close byte are forwarded, 0F fills
         // are invisible in the filtered view, and one F0 always closes.
         stop_idx = -1;
         foreach (pl[i]) if (stop_idx < 0 && pl[i] == STOP) stop_idx = i;
         exp_stop = (stop_idx >= 0);
         exp_cons = exp_stop ? stop_idx + 1 : len;
         exp_q.delete();
         for (int i = 0; i < exp_cons; i++) if (pl[i] != STOP && pl[i] != SAFE) exp_q.push_back(pl[i]);
         exp_q.push_back(STOP);
         src_q = pl;
         run_xfer(len, vmode, hold, 400);
         ok = (fil_q.size() == exp_q.size());
         if (ok) foreach (exp_q[i]) if (fil_q[i] !== exp_q[i]) ok = 1'b0;
         n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_wire[%0d]: %0d bytes seen, %0d expected (or content differs)", t, fil_q.size(), exp_q.size()); end
         n_tests++; if (res_consumed !== exp_cons) begin n_fail++; $display("FAIL rand_consumed[%0d]: got %0d want %0d", t, res_consumed, exp_cons); end
         n_tests++; if (en1_q.size() !== 2 || en1_q[0] !== START || en1_q[1] !== SAFE) begin n_fail++; $display("FAIL rand_en[%0d]: %0d enable cycles, want A5 then 0f", t, en1_q.size()); end
         n_tests++; if ({res_ndone, res_nerr} !== (exp_stop ? {32'd0, 32'd1} : {32'd1, 32'd0})) begin n_fail++; $display("FAIL rand_outcome[%0d]: done %0d err %0d stop %0d", t, res_ndone, res_nerr, exp_stop); end
         n_tests++; if (res_code !== (exp_stop ? 2'b10 : 2'b00) || res_both) begin n_fail++; $display("FAIL rand_code[%0d]: got %b both %0d want %b", t, res_code, res_both, exp_stop ? 2'b10 : 2'b00); end
         if (vmode == 0 && !exp_stop) begin
            n_tests++; if (res_done_k !== len + 7) begin n_fail++; $display("FAIL rand_latency[%0d]: done at %0d want %0d", t, res_done_k, len + 7); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ideal_len3();
      test_stall_len4();
      test_stop_in_payload();
      test_timeout();
      test_zero_len_and_ignore();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fsm_link_driver.md
Name: fsm_link_driver

Overview:
Transmit-side driver for the byte/enable link consumed by our IDLE/ON/OFF/WAIT link FSM. It takes a framed request (length plus streamed payload) and generates the data/en sequence that walks the peer through IDLE→ON→OFF→WAIT→IDLE. It monitors the peer's 3-bit state, and reports done, or an error on timeout or an illegal payload. It sits between the command source and the link FSM.

Parameters:
START_BYTE, 8'hA5, open byte sent with en=1; must differ from 8'h0F and STOP_BYTE
STOP_BYTE, 8'hF0, close byte; forces peer ON→OFF
SAFE_BYTE, 8'h0F, byte driven whenever no byte is active; never opens the peer
TIMEOUT, 255, max cycles spent in any wait-for-peer state; 8-bit counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  transfer request
req_len  input  5  payload byte count, 1..16; 0 is illegal
req_ready  output  1  high only in D_IDLE
pl_valid  input  1  payload byte available
pl_data  input  8  payload byte
pl_ready  output  1  payload byte consumed this cycle
peer_state  input  3  peer state encoding: IDLE=000, ON=001, OFF=010, WAIT=100
data  output  8  link data to peer
en  output  1  link enable to peer
busy  output  1  high in every state except D_IDLE
done  output  1  one-cycle pulse on clean completion
err  output  1  one-cycle pulse on abort
err_code  output  2  01 timeout, 10 stop byte in payload, 11 zero length; held until next request

Behaviour:
- Reset (asynchronous, any state):
  - state=D_IDLE, data=SAFE_BYTE, en=0.
  - req_ready=1, pl_ready=0, busy=0, done=0, err=0, err_code=00.
  - Counters cleared.
- All outputs are registered.
- Accept a request on req_valid&&req_ready. Latch req_len into remaining and clear err_code.
- States:
  - D_IDLE
    - data=SAFE_BYTE, en=0.
    - On accept with req_len=0: err pulse, err_code=11, stay in D_IDLE.
    - On accept otherwise: go to D_OPEN.
  - D_OPEN: one cycle, data=START_BYTE, en=1. Then D_WAIT_ON.
  - D_WAIT_ON
    - data=SAFE_BYTE, en=0. Wait for peer_state==001, then D_PAYLOAD.
  - D_PAYLOAD
    - pl_ready=1 while remaining>0.
    - On pl_valid&&pl_ready: data=pl_data, en=0, decrement remaining.
    - Cycles with no byte transferred drive data=SAFE_BYTE; this is a stall and the peer stays ON.
    - When remaining reaches 0, go to D_STOP the next cycle.
    - If pl_data==STOP_BYTE: do not forward it, set err_code=10, go to D_STOP (the peer is still closed cleanly).
  - D_STOP: one cycle, data=STOP_BYTE, en=0. Then D_WAIT_OFF.
  - D_WAIT_OFF: wait for peer_state==010, then D_CLOSE.
  - D_CLOSE: one cycle, en=1, data=SAFE_BYTE. Then D_WAIT_IDLE.
  - D_WAIT_IDLE
    - Wait for peer_state==000; passing through 100 is expected.
    - Then pulse done (if err_code==00) or err (if err_code==10). Return to D_IDLE.
- Timeout:
  - In each D_WAIT_* state, count cycles from 0. The counter resets on entry.
  - If the count reaches TIMEOUT: err pulse, err_code=01, data=SAFE_BYTE, en=0, go to D_IDLE.
  - No done pulse is issued on timeout.
- done and err are never high together.
- req_valid outside D_IDLE is ignored; the request is not latched.
- Minimum transfer latency with an ideal peer (responds next cycle) and pl_valid held high: accept → done = len+7 cycles.
- Peer-state values outside the expected one are ignored by all waits (no early exit).
- A SAFE_BYTE occurring inside the payload is forwarded unchanged; it is legal in ON.

Test Plan:
1. Reset mid-D_PAYLOAD (rst asserted asynchronously between edges) → data=8'h0F, en=0, busy=0, req_ready=1 immediately; no done or err.
2. Ideal peer model, req_len=3, payload 11,22,33, pl_valid always high:
   - Link sees A5/en=1, then 0F, 11, 22, 33, F0, then en=1 pulse.
   - done pulses exactly 10 cycles after accept; err_code=00.
3. req_len=4 with pl_valid low on alternate cycles → 0F fill bytes between payload bytes; exactly 4 bytes forwarded; done pulses; pl_ready low once remaining=0.
4. Payload byte F0 as the 2nd of 4 → first byte forwarded, F0 not forwarded as payload, single F0 close; err pulse with err_code=10 after the peer returns to 000; no done.
5. Peer stuck at 000 after open → err pulse at cycle TIMEOUT of D_WAIT_ON, err_code=01, back to D_IDLE; next request accepted normally.
6. req_len=0 → single err pulse, err_code=11, no link activity (en stays 0); req_valid during busy is ignored with no second transfer.
